// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD sequencer slice.
// sat_inc16 exists only when GCD_SEQ_CYCLE_COUNT_EN is defined.
package gcd_pkg;

   localparam int unsigned GcdWidthDefault = 8;
   localparam int unsigned GcdDepthDefault = 4;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StHold
   } gcd_state_e;

`ifdef GCD_SEQ_CYCLE_COUNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

endpackage

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO. Pointers carry one extra wrap bit to tell full from empty.
module gcd_pair_fifo #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = (AW + 1)'(1);

   logic [AW:0]   wptr_q, rptr_q;
   logic [DW-1:0] mem_q [DEPTH];
   logic          push_en, pop_en;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign rdata   = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!nrst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_en) wptr_q <= wptr_q + PtrOne;
         if (pop_en)  rptr_q <= rptr_q + PtrOne;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/gcd_sequencer.sv
// Queues operand pairs, feeds them to an external GCD core and holds each result for pop.
// Define GCD_SEQ_CYCLE_COUNT_EN to add the res_cycles latency output.
module gcd_sequencer
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH = GcdWidthDefault,
   parameter int unsigned DEPTH = GcdDepthDefault
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             gcd_start,
   output logic [WIDTH-1:0] gcd_ina,
   output logic [WIDTH-1:0] gcd_inb,
   input  logic             gcd_ready,
   input  logic [WIDTH-1:0] gcd_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_gcd
`ifdef GCD_SEQ_CYCLE_COUNT_EN
   ,
   output logic [15:0]      res_cycles
`endif
);

   gcd_state_e         state_q;
   logic               wait_first_q;
   logic [2*WIDTH-1:0] head;
   logic [WIDTH-1:0]   head_a, head_b;
   logic               fifo_full, fifo_empty;
   logic               bypass, pop, capture;

   gcd_pair_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (in_valid),
      .wdata ({in_a, in_b}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign head_a   = head[2*WIDTH-1:WIDTH];
   assign head_b   = head[WIDTH-1:0];
   // The core never finishes on a zero operand, so such pairs skip it.
   assign bypass   = (head_a == '0) || (head_b == '0);
   assign pop      = (state_q == StIdle) && !fifo_empty && (bypass || gcd_ready);
   // The core may still show the previous ready in the first WAIT cycle.
   assign capture  = (state_q == StWait) && !wait_first_q && gcd_ready;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q      <= StIdle;
         wait_first_q <= 1'b0;
         gcd_start    <= 1'b0;
         gcd_ina      <= '0;
         gcd_inb      <= '0;
         res_valid    <= 1'b0;
         res_gcd      <= '0;
      end else begin
         gcd_start <= 1'b0;
         case (state_q)
            StIdle: begin
               if (pop) begin
                  if (bypass) begin
                     res_gcd   <= head_a | head_b;
                     res_valid <= 1'b1;
                     state_q   <= StHold;
                  end else begin
                     gcd_ina   <= head_a;
                     gcd_inb   <= head_b;
                     gcd_start <= 1'b1;
                     state_q   <= StIssue;
                  end
               end
            end
            StIssue: begin
               wait_first_q <= 1'b1;
               state_q      <= StWait;
            end
            StWait: begin
               wait_first_q <= 1'b0;
               if (capture) begin
                  res_gcd   <= gcd_out;
                  res_valid <= 1'b1;
                  state_q   <= StHold;
               end
            end
            StHold: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef GCD_SEQ_CYCLE_COUNT_EN
   logic [15:0] cyc_q;

   // cyc_q counts the ISSUE cycle plus each WAIT cycle before the capture edge.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         cyc_q      <= '0;
         res_cycles <= '0;
      end else begin
         case (state_q)
            StIdle:  if (pop && bypass) res_cycles <= '0;
            StIssue: cyc_q <= 16'd1;
            StWait: begin
               if (capture) res_cycles <= sat_inc16(cyc_q);
               else         cyc_q      <= sat_inc16(cyc_q);
            end
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed bench for gcd_sequencer with a behavioural subtractive GCD core.
// Exercises res_cycles as well when GCD_SEQ_CYCLE_COUNT_EN is defined.
module tb_gcd_sequencer;

   logic       clk = 1'b0;
   logic       nrst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a, in_b;
   logic       gcd_start;
   logic [7:0] gcd_ina, gcd_inb;
   logic       gcd_ready;
   logic [7:0] gcd_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_gcd;
`ifdef GCD_SEQ_CYCLE_COUNT_EN
   logic [15:0] res_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;

   gcd_sequencer #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .gcd_start (gcd_start),
      .gcd_ina   (gcd_ina),
      .gcd_inb   (gcd_inb),
      .gcd_ready (gcd_ready),
      .gcd_out   (gcd_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_gcd   (res_gcd)
`ifdef GCD_SEQ_CYCLE_COUNT_EN
      ,
      .res_cycles (res_cycles)
`endif
   );

   // Behavioural core: one subtraction per cycle, shares nrst with the DUT.
   logic       core_ready_q, core_busy_q, stall;
   logic [7:0] ca_q, cb_q, core_out_q;

   assign gcd_ready = core_ready_q && !stall;
   assign gcd_out   = core_out_q;

   always @(posedge clk) begin
      if (!nrst) begin
         core_ready_q <= 1'b1;
         core_busy_q  <= 1'b0;
         core_out_q   <= '0;
         ca_q         <= '0;
         cb_q         <= '0;
      end else if (gcd_start) begin
         ca_q         <= gcd_ina;
         cb_q         <= gcd_inb;
         core_busy_q  <= 1'b1;
         core_ready_q <= 1'b0;
      end else if (core_busy_q) begin
         if (ca_q > cb_q)      ca_q <= ca_q - cb_q;
         else if (cb_q > ca_q) cb_q <= cb_q - ca_q;
         else begin
            core_out_q   <= ca_q;
            core_ready_q <= 1'b1;
            core_busy_q  <= 1'b0;
         end
      end
   end

   always @(posedge clk) if (gcd_start) start_cnt <= start_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      check("in_ready_before_push", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!res_valid && n < 400) begin
         tick();
         n++;
      end
      check({tag, "_res_valid_timeout"}, 32'(res_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int seen;
      logic [7:0] exp_q [4];
      exp_q = '{8'd4, 8'd3, 8'd5, 8'd7};

      nrst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      res_ready = 1'b0; stall = 1'b0;
      tick(); tick();
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_gcd_start", 32'(gcd_start), 32'd0);
      check("rst_res_gcd",   32'(res_gcd),   32'd0);
      check("rst_gcd_ina",   32'(gcd_ina),   32'd0);
      check("rst_gcd_inb",   32'(gcd_inb),   32'd0);
      nrst = 1'b1;
      tick();

      // (12,18): start two cycles after the push edge, result 6
      res_ready = 1'b1;
      s0 = start_cnt;
      push(8'd12, 8'd18);
      check("p12_start_k1", 32'(gcd_start), 32'd0);
      tick();
      check("p12_start_k2", 32'(gcd_start), 32'd1);
      check("p12_ina", 32'(gcd_ina), 32'd12);
      check("p12_inb", 32'(gcd_inb), 32'd18);
      tick();
      check("p12_start_pulse_end", 32'(gcd_start), 32'd0);
      wait_valid("p12");
      check("p12_res", 32'(res_gcd), 32'd6);
      tick();
      check("p12_popped", 32'(res_valid), 32'd0);
      check("p12_start_count", 32'(start_cnt - s0), 32'd1);

      // Bypass pairs: (7,0) -> 7, (0,0) -> 0, no core activity
      s0 = start_cnt;
      push(8'd7, 8'd0);
      check("byp7_valid_k1", 32'(res_valid), 32'd0);
      tick();
      check("byp7_valid_k2", 32'(res_valid), 32'd1);
      check("byp7_res", 32'(res_gcd), 32'd7);
      tick();
      check("byp7_popped", 32'(res_valid), 32'd0);
      push(8'd0, 8'd0);
      tick();
      check("byp0_valid_k2", 32'(res_valid), 32'd1);
      check("byp0_res", 32'(res_gcd), 32'd0);
      tick();
      check("byp_no_start", 32'(start_cnt - s0), 32'd0);

      // Fill the FIFO while the core reports busy, then drain in order
      stall = 1'b1;
      res_ready = 1'b0;
      push(8'd8, 8'd4);
      push(8'd9, 8'd6);
      push(8'd5, 8'd5);
      push(8'd21, 8'd14);
      check("fill_in_ready_low", 32'(in_ready), 32'd0);
      check("fill_no_start", 32'(gcd_start), 32'd0);
      stall = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_valid("drain");
         check("drain_res", 32'(res_gcd), 32'(exp_q[i]));
         tick();
      end

      // Reset during WAIT discards the in-flight and the queued pair
      push(8'd255, 8'd1);
      push(8'd6, 8'd9);
      tick();
      nrst = 1'b0;
      tick();
      check("mid_rst_res_valid", 32'(res_valid), 32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd1);
      check("mid_rst_gcd_start", 32'(gcd_start), 32'd0);
      check("mid_rst_gcd_ina",   32'(gcd_ina),   32'd0);
      nrst = 1'b1;
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (res_valid) seen++;
      end
      check("mid_rst_no_stale", 32'(seen), 32'd0);
      push(8'd10, 8'd4);
      wait_valid("after_rst");
      check("after_rst_res", 32'(res_gcd), 32'd2);
      tick();

      // Result held stable under back-pressure
      res_ready = 1'b0;
      push(8'd100, 8'd75);
      wait_valid("hold");
      check("hold_res", 32'(res_gcd), 32'd25);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", 32'(res_valid), 32'd1);
         check("hold_res_stable", 32'(res_gcd), 32'd25);
      end
      res_ready = 1'b1;
      tick();
      check("hold_released", 32'(res_valid), 32'd0);

`ifdef GCD_SEQ_CYCLE_COUNT_EN
      begin
         int n;
         int cyc;
         push(8'd3, 8'd3);
         n = 0;
         while (!gcd_start && n < 10) begin
            tick();
            n++;
         end
         check("cyc_start_seen", 32'(gcd_start), 32'd1);
         cyc = 0;
         while (!res_valid && cyc < 100) begin
            cyc++;
            tick();
         end
         check("cyc_valid", 32'(res_valid), 32'd1);
         check("cyc_measured", 32'(cyc), 32'd3);
         check("cyc_res_cycles", 32'(res_cycles), 32'(cyc));
         tick();
         push(8'd4, 8'd0);
         tick();
         check("cyc_byp_valid", 32'(res_valid), 32'd1);
         check("cyc_byp_res", 32'(res_gcd), 32'd4);
         check("cyc_byp_cycles", 32'(res_cycles), 32'd0);
         tick();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
